// File: rtl/seq_table_pkg.sv
// rtl/seq_table_pkg.sv - shared types and constants for the sequencer table store
package seq_table_pkg;

    localparam int FRAME_WORDS = 4;
    localparam int WORD_W      = 32;
    localparam int FRAME_W     = FRAME_WORDS * WORD_W;

    typedef logic [FRAME_W-1:0] frame_t;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_LOAD  = 2'd1,
        RD_VALID = 2'd2
    } rd_state_e;

    // Word k of a frame sits at bits [32k+31:32k].
    function automatic logic [WORD_W-1:0] frame_word(input frame_t f, input int k);
        return f[k*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/seq_table_if.sv
// rtl/seq_table_if.sv - register-side and core-side signals of the table store
interface seq_table_if #(
    parameter int DEPTH = 1024,
    parameter int LEN_W = 16
);
    import seq_table_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              table_rst_i;
    logic              table_wstb_i;
    logic [31:0]       table_data_i;
    logic              table_len_wstb_i;
    logic [LEN_W-1:0]  table_len_i;
    logic              frame_req_i;

    logic              table_ready_o;
    logic              frame_vld_o;
    frame_t            frame_o;
    logic [LEN_W-1:0]  frame_idx_o;
    logic              frame_last_o;
    logic [CNT_W-1:0]  wr_words_o;
    logic              table_err_o;

    modport master (
        output table_rst_i, table_wstb_i, table_data_i,
               table_len_wstb_i, table_len_i, frame_req_i,
        input  table_ready_o, frame_vld_o, frame_o, frame_idx_o,
               frame_last_o, wr_words_o, table_err_o
    );

    modport slave (
        input  table_rst_i, table_wstb_i, table_data_i,
               table_len_wstb_i, table_len_i, frame_req_i,
        output table_ready_o, frame_vld_o, frame_o, frame_idx_o,
               frame_last_o, wr_words_o, table_err_o
    );

endinterface

// File: rtl/seq_table_ram.sv
// rtl/seq_table_ram.sv - DEPTH x 32 simple dual-port RAM with registered read
module seq_table_ram #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk_i,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [31:0]              wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/seq_table_ctrl.sv
// rtl/seq_table_ctrl.sv - table write/commit logic and 4-word frame reader
module seq_table_ctrl
    import seq_table_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int LEN_W = 16
) (
    input  logic       clk_i,
    input  logic       reset_i,
    seq_table_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int XW = LEN_W + CW + 2;

    localparam logic [1:0] S_IDLE  = RD_IDLE;
    localparam logic [1:0] S_LOAD  = RD_LOAD;
    localparam logic [1:0] S_VALID = RD_VALID;

    logic [CW-1:0]    wr_words;
    logic             table_ready;
    logic             table_err;
    logic [LEN_W-1:0] tbl_len;
    logic [LEN_W-1:0] cur_idx;
    logic [1:0]       state;
    logic [2:0]       ld_cnt;
    logic [95:0]      stage;
    frame_t           frame_q;
    logic             frame_vld;
    logic [LEN_W-1:0] frame_idx;
    logic             frame_last;

    logic             full;
    logic             wr_accept;
    logic             wr_reject;
    logic             len_ok;
    logic             commit_ok;
    logic             commit_bad;
    logic             req_take;

    logic             ram_re;
    logic [AW-1:0]    ram_raddr;
    logic [31:0]      ram_rdata;

    // TRST overrides every other strobe arriving in the same cycle.
    always_comb begin
        full       = (wr_words == CW'(DEPTH));
        wr_accept  = bus.table_wstb_i && !bus.table_rst_i && !table_ready && !full;
        wr_reject  = bus.table_wstb_i && !bus.table_rst_i && (table_ready || full);
        len_ok     = (bus.table_len_i != '0) &&
                     (XW'({bus.table_len_i, 2'b00}) <= XW'(wr_words));
        commit_ok  = bus.table_len_wstb_i && !bus.table_rst_i && !table_ready && len_ok;
        commit_bad = bus.table_len_wstb_i && !bus.table_rst_i && !commit_ok;
        req_take   = bus.frame_req_i && !bus.table_rst_i && (state == S_VALID);
    end

    assign ram_re    = (state == S_LOAD) && !ld_cnt[2];
    assign ram_raddr = AW'({cur_idx, ld_cnt[1:0]});

    seq_table_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i (clk_i),
        .we    (wr_accept),
        .waddr (wr_words[AW-1:0]),
        .wdata (bus.table_data_i),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_words    <= '0;
            table_ready <= 1'b0;
            table_err   <= 1'b0;
            tbl_len     <= '0;
            cur_idx     <= '0;
            state       <= S_IDLE;
            ld_cnt      <= '0;
            stage       <= '0;
            frame_q     <= '0;
            frame_vld   <= 1'b0;
            frame_idx   <= '0;
            frame_last  <= 1'b0;
        end else if (bus.table_rst_i) begin
            wr_words    <= '0;
            table_ready <= 1'b0;
            table_err   <= 1'b0;
            tbl_len     <= '0;
            cur_idx     <= '0;
            state       <= S_IDLE;
            ld_cnt      <= '0;
            frame_q     <= '0;
            frame_vld   <= 1'b0;
            frame_idx   <= '0;
            frame_last  <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_words <= wr_words + CW'(1);
            end
            if (wr_reject || commit_bad) begin
                table_err <= 1'b1;
            end
            if (commit_ok) begin
                tbl_len     <= bus.table_len_i;
                table_ready <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (commit_ok) begin
                        state   <= S_LOAD;
                        cur_idx <= '0;
                        ld_cnt  <= '0;
                    end
                end
                S_LOAD: begin
                    // ld_cnt = n means read n-1 has just landed on ram_rdata.
                    case (ld_cnt)
                        3'd1: stage[31:0]  <= ram_rdata;
                        3'd2: stage[63:32] <= ram_rdata;
                        3'd3: stage[95:64] <= ram_rdata;
                        default: ;
                    endcase
                    if (ld_cnt == 3'd4) begin
                        frame_q    <= {ram_rdata, stage};
                        frame_idx  <= cur_idx;
                        frame_last <= (cur_idx == tbl_len - LEN_W'(1));
                        frame_vld  <= 1'b1;
                        ld_cnt     <= '0;
                        state      <= S_VALID;
                    end else begin
                        ld_cnt <= ld_cnt + 3'd1;
                    end
                end
                S_VALID: begin
                    if (req_take) begin
                        frame_vld <= 1'b0;
                        cur_idx   <= frame_last ? '0 : cur_idx + LEN_W'(1);
                        ld_cnt    <= '0;
                        state     <= S_LOAD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.table_ready_o = table_ready;
    assign bus.frame_vld_o   = frame_vld;
    assign bus.frame_o       = frame_q;
    assign bus.frame_idx_o   = frame_idx;
    assign bus.frame_last_o  = frame_last;
    assign bus.wr_words_o    = wr_words;
    assign bus.table_err_o   = table_err;

endmodule

// File: tb/tb_seq_table_ctrl.sv
// tb/tb_seq_table_ctrl.sv - scoreboard bench for seq_table_ctrl
module tb_seq_table_ctrl;

    localparam int DEPTH = 8;
    localparam int LEN_W = 16;

    typedef struct {
        logic [127:0] frame;
        int           idx;
        logic         last;
        int           cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_pass;
    int   n_total;
    exp_t sb[$];
    logic vld_prev;

    seq_table_if #(.DEPTH(DEPTH), .LEN_W(LEN_W)) bus ();

    seq_table_ctrl #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [127:0] mkf(input int a);
        return {32'(a + 3), 32'(a + 2), 32'(a + 1), 32'(a)};
    endfunction

    task automatic push(input int base, input int idx, input logic last, input int at);
        exp_t e;
        e.frame = mkf(base);
        e.idx   = idx;
        e.last  = last;
        e.cyc   = at;
        sb.push_back(e);
    endtask

    // Monitor: every rising frame_vld_o is matched against the oldest expectation.
    initial vld_prev = 1'b0;
    always @(negedge clk) begin
        if (bus.frame_vld_o && !vld_prev) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_frame: got frame %0h idx %0d expected none",
                         bus.frame_o, bus.frame_idx_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("frame_data", bus.frame_o, e.frame);
                check("frame_idx", 128'(bus.frame_idx_o), 128'(e.idx));
                check("frame_last", 128'(bus.frame_last_o), 128'(e.last));
                check("frame_cycle", 128'(cyc), 128'(e.cyc));
            end
        end
        vld_prev <= bus.frame_vld_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_trst();
        bus.table_rst_i = 1'b1;
        tick();
        bus.table_rst_i = 1'b0;
    endtask

    task automatic do_wr(input int d);
        bus.table_data_i = 32'(d);
        bus.table_wstb_i = 1'b1;
        tick();
        bus.table_wstb_i = 1'b0;
    endtask

    task automatic do_len(input int len);
        bus.table_len_i      = LEN_W'(len);
        bus.table_len_wstb_i = 1'b1;
        tick();
        bus.table_len_wstb_i = 1'b0;
    endtask

    task automatic do_req();
        bus.frame_req_i = 1'b1;
        tick();
        bus.frame_req_i = 1'b0;
    endtask

    task automatic wait_vld(input string name);
        int k;
        for (k = 0; k < 20; k++) begin
            if (bus.frame_vld_o) break;
            tick();
        end
        if (!bus.frame_vld_o) begin
            n_total++;
            $display("FAIL %s_timeout: got frame_vld_o 0 expected 1 within 20 cycles", name);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ready"}, 128'(bus.table_ready_o), 128'(0));
        check({name, "_vld"}, 128'(bus.frame_vld_o), 128'(0));
        check({name, "_frame"}, bus.frame_o, 128'(0));
        check({name, "_idx_last"}, 128'({bus.frame_idx_o, bus.frame_last_o}), 128'(0));
        check({name, "_words_err"}, 128'({bus.wr_words_o, bus.table_err_o}), 128'(0));
    endtask

    initial begin
        int cnt;
        int c;
        n_pass  = 0;
        n_total = 0;
        rst = 1'b1;
        bus.table_rst_i      = 1'b0;
        bus.table_wstb_i     = 1'b0;
        bus.table_data_i     = '0;
        bus.table_len_wstb_i = 1'b0;
        bus.table_len_i      = '0;
        bus.frame_req_i      = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Basic serve and wrap
        do_trst();
        for (int i = 1; i <= 8; i++) do_wr(i);
        check("wr_words_8", 128'(bus.wr_words_o), 128'(8));
        do_len(2);
        push(1, 0, 1'b0, cyc + 5);
        check("commit_ready", 128'(bus.table_ready_o), 128'(1));
        check("commit_err", 128'(bus.table_err_o), 128'(0));
        wait_vld("first");
        do_req();
        check("vld_falls", 128'(bus.frame_vld_o), 128'(0));
        push(5, 1, 1'b1, cyc + 5);
        wait_vld("second");
        do_req();
        push(1, 0, 1'b0, cyc + 5);
        wait_vld("wrap");

        // TLEN while a table is committed: error, length unchanged
        do_len(1);
        check("relen_err", 128'(bus.table_err_o), 128'(1));
        check("relen_ready", 128'(bus.table_ready_o), 128'(1));
        do_req();
        push(5, 1, 1'b1, cyc + 5);
        wait_vld("relen");

        // Bad length
        do_trst();
        check("trst_clears_err", 128'(bus.table_err_o), 128'(0));
        for (int i = 10; i <= 17; i++) do_wr(i);
        do_len(3);
        check("badlen_err", 128'(bus.table_err_o), 128'(1));
        check("badlen_ready", 128'(bus.table_ready_o), 128'(0));
        repeat (8) tick();
        check("badlen_no_vld", 128'(bus.frame_vld_o), 128'(0));
        do_trst();
        check("badlen_trst_err", 128'(bus.table_err_o), 128'(0));

        // Locked table
        for (int i = 40; i <= 43; i++) do_wr(i);
        do_len(1);
        push(40, 0, 1'b1, cyc + 5);
        wait_vld("locked");
        do_wr(99);
        check("locked_err", 128'(bus.table_err_o), 128'(1));
        check("locked_words", 128'(bus.wr_words_o), 128'(4));
        check("locked_frame", bus.frame_o, mkf(40));

        // Overflow at DEPTH words
        do_trst();
        for (int i = 20; i <= 28; i++) do_wr(i);
        check("ovf_words", 128'(bus.wr_words_o), 128'(8));
        check("ovf_err", 128'(bus.table_err_o), 128'(1));
        do_len(2);
        check("ovf_ready", 128'(bus.table_ready_o), 128'(1));
        push(20, 0, 1'b0, cyc + 5);
        wait_vld("ovf0");
        do_req();
        push(24, 1, 1'b1, cyc + 5);
        wait_vld("ovf1");
        do_req();
        push(20, 0, 1'b0, cyc + 5);
        wait_vld("ovf2");

        // TRST two cycles after a request, mid-LOAD
        do_req();
        tick();
        do_trst();
        check("midload_vld", 128'(bus.frame_vld_o), 128'(0));
        check("midload_idx", 128'(bus.frame_idx_o), 128'(0));
        check("midload_ready", 128'(bus.table_ready_o), 128'(0));
        repeat (8) tick();
        check("midload_quiet", 128'(bus.frame_vld_o), 128'(0));
        for (int i = 30; i <= 33; i++) do_wr(i);
        do_len(1);
        push(30, 0, 1'b1, cyc + 5);
        wait_vld("reload");

        // Continuous request with TLEN=1
        c = cyc;
        bus.frame_req_i = 1'b1;
        push(30, 0, 1'b1, c + 6);
        push(30, 0, 1'b1, c + 12);
        push(30, 0, 1'b1, c + 18);
        cnt = 0;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (bus.frame_vld_o) cnt++;
            if (k == 18) bus.frame_req_i = 1'b0;
        end
        check("cont_pulses", 128'(cnt), 128'(3));
        tick();
        check("cont_hold_vld", 128'(bus.frame_vld_o), 128'(1));
        check("cont_idx", 128'(bus.frame_idx_o), 128'(0));

        // Async reset while VALID
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async");
        tick();
        tick();
        rst = 1'b0;
        tick();
        do_len(1);
        check("post_reset_err", 128'(bus.table_err_o), 128'(1));
        check("post_reset_ready", 128'(bus.table_ready_o), 128'(0));
        repeat (8) tick();
        check("post_reset_no_vld", 128'(bus.frame_vld_o), 128'(0));

        check("scoreboard_empty", 128'(sb.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seq_table_ctrl.md
# seq_table_ctrl

Table store and frame reader behind the sequencer's table registers. It is the responder to the TRST/TDAT/TLEN register writes: it accepts 32-bit table words from the register bus, holds them in block RAM and commits a table of TLEN frames. On request it then serves 4-word frames to the sequencer core, wrapping from the last frame to the first. It sits between the sequencer register decode and the sequencer core state machine.

## Interface
Parameters:
- DEPTH, 1024: table capacity in 32-bit words; must be a multiple of 4 and a power of two.
- LEN_W, 16: width of TLEN and the frame index.

Ports:
- clk_i  in  1  system clock; the only clock.
- reset_i  in  1  asynchronous, active-high reset.
- table_rst_i  in  1  TRST write strobe; single-cycle.
- table_wstb_i  in  1  TDAT write strobe; single-cycle.
- table_data_i  in  32  TDAT write data.
- table_len_wstb_i  in  1  TLEN write strobe; commits the table.
- table_len_i  in  LEN_W  TLEN value, in frames.
- frame_req_i  in  1  core request to advance to the next frame.
- table_ready_o  out  1  a committed table is valid.
- frame_vld_o  out  1  frame_o holds a valid frame.
- frame_o  out  128  current frame; [32k+31:32k] = word 4·idx+k.
- frame_idx_o  out  LEN_W  current frame index (CUR_FRAME).
- frame_last_o  out  1  frame_idx_o = TLEN−1.
- wr_words_o  out  log2(DEPTH)+1  words written since the last TRST.
- table_err_o  out  1  sticky error flag.

## Operation
- Write side:
  - TRST clears the word count, clears table_ready_o and table_err_o, and sends the reader to IDLE.
  - TDAT writes the word at address wr_words and increments the count.
  - A TDAT write when the count equals DEPTH is dropped and sets the error flag.
  - A TDAT write while table_ready_o=1 is dropped and sets the error flag; the table is locked until TRST.
- Commit (TLEN strobe):
  - Accepted when 1 ≤ TLEN and 4·TLEN ≤ wr_words. The length is latched and table_ready_o is set.
  - Otherwise the error flag is set and table_ready_o stays 0.
- Reader state machine:
  - IDLE: frame_vld_o=0, index 0. Moves to LOAD on an accepted commit.
  - LOAD: issues 4 consecutive RAM reads for the current index, then moves to VALID.
  - VALID: frame_vld_o=1. On frame_req_i the index increments, wrapping to 0 after TLEN−1, and the state returns to LOAD.
- frame_req_i is ignored outside VALID.
- TRST and frame_req_i in the same cycle: TRST wins.
- TLEN strobe while table_ready_o=1 without a preceding TRST: sets the error flag and leaves the committed table unchanged.

## Timing
- Reset values: all outputs 0, state IDLE.
- Commit accepted at edge E: table_ready_o=1 after E.
- RAM read latency is one registered cycle. With the commit or request accepted at edge E:
  - addresses are issued at E+1..E+4;
  - data is captured at E+2..E+5;
  - frame_vld_o=1 after E+5.
- frame_vld_o falls after the edge that accepts frame_req_i.
- frame_o, frame_idx_o and frame_last_o update together with the rise of frame_vld_o and are stable while it is high.
- TRST at any state, including mid-LOAD: after that edge, table_ready_o=0, frame_vld_o=0, state IDLE, index 0.
- Back-to-back requests: frame_vld_o is high for at least 1 cycle per frame. The minimum frame period is 6 cycles.

## Structure
- Shared package seq_table_pkg holds:
  - FRAME_WORDS=4;
  - the 128-bit frame type;
  - the reader state enum (IDLE, LOAD, VALID).
- Sub-module seq_table_ram: simple dual-port RAM, DEPTH×32, one write port, one registered read port.
- The top level holds the write counter, the commit/error logic and the reader state machine.

## Test plan
- Basic serve and wrap: TRST; TDAT 1..8; TLEN=2.
  - Expect table_ready_o=1, and 6 cycles after the commit edge frame_vld_o=1 with frame_o words {1,2,3,4}, idx 0, last 0.
  - First request → {5,6,7,8}, idx 1, last 1.
  - Second request → {1,2,3,4}, idx 0.
- Bad length: TRST; 8 words; TLEN=3 → table_err_o=1, table_ready_o=0, frame_vld_o stays 0. A following TRST clears table_err_o.
- Overflow with DEPTH=8: write 9 words → wr_words_o=8, table_err_o=1, and RAM words 0..7 are unchanged.
- TRST mid-LOAD: assert TRST 2 cycles after a request → frame_vld_o=0, frame_idx_o=0, table_ready_o=0. Reload with 4 words and TLEN=1 → a valid frame appears again.
- Continuous request, TLEN=1: frame_req_i held high → frame_idx_o stays 0 and frame_vld_o pulses for 1 cycle every 6 cycles.
- Locked table: after commit, write TDAT=99 → table_err_o=1 and frame contents are unchanged.
- Async reset mid-VALID: all outputs 0 immediately. After release, TLEN without new TDAT → error, because the word count was cleared.
